// File: rtl/osd_him_pkg.sv
// Shared definitions for the host interface egress/ingress paths:
// FSM state encoding, size-field width and the wire-format byte swap.
package osd_him_pkg;

  localparam int SIZE_FIELD_W = 5;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_SEND_SIZE = 2'd1,
    ST_SEND_DATA = 2'd2
  } him_state_e;

  // GLIP words travel big-endian; DII words are native order
  function automatic logic [15:0] bswap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/osd_him_pktbuf.sv
// Single-packet store: one write port, one asynchronous read port.
// Contents are not reset; only addresses below the fill count are ever read.
module osd_him_pktbuf
  import osd_him_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/osd_him_egress.sv
// Host interface egress: store-and-forward one DII packet, then emit a
// byte-swapped size word followed by the byte-swapped packet words on GLIP.
module osd_him_egress
  import osd_him_pkg::*;
#(
  parameter int MAX_PKT_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dii_data_i,
  input  logic        dii_valid_i,
  input  logic        dii_first_i,
  input  logic        dii_last_i,
  output logic        dii_ready_o,
  output logic [15:0] glip_data_o,
  output logic        glip_valid_o,
  input  logic        glip_ready_i,
  output logic        err_overflow_o,
  output logic        err_framing_o
);

  localparam int AW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
  localparam logic [SIZE_FIELD_W-1:0] MAX_LEN_C = SIZE_FIELD_W'(MAX_PKT_LEN);

  him_state_e              state_q, state_d;
  logic [SIZE_FIELD_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [SIZE_FIELD_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                    in_pkt_q, in_pkt_d;
  logic                    trunc_q, trunc_d;
  logic                    err_of_q, err_of_d;
  logic                    err_fr_q, err_fr_d;

  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [15:0]   rdata_s;

  osd_him_pktbuf #(
    .DEPTH (MAX_PKT_LEN),
    .AW    (AW)
  ) u_pktbuf (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (dii_data_i),
    .raddr_i (rd_cnt_q[AW-1:0]),
    .rdata_o (rdata_s)
  );

  // Next-state: packet framing/truncation during fill, word sequencing during send
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    in_pkt_d = in_pkt_q;
    trunc_d  = trunc_q;
    err_of_d = 1'b0;
    err_fr_d = 1'b0;
    we_s     = 1'b0;
    waddr_s  = wr_cnt_q[AW-1:0];
    case (state_q)
      ST_FILL: begin
        if (dii_valid_i) begin
          if (dii_first_i) begin
            // a restart abandons whatever partial packet was in flight
            err_fr_d = in_pkt_q;
            we_s     = 1'b1;
            waddr_s  = '0;
            wr_cnt_d = SIZE_FIELD_W'(1);
            in_pkt_d = 1'b1;
            trunc_d  = 1'b0;
            if (dii_last_i) begin
              state_d  = ST_SEND_SIZE;
              in_pkt_d = 1'b0;
            end else begin
              state_d  = ST_FILL;
            end
          end else if (!in_pkt_q) begin
            err_fr_d = 1'b1;
          end else begin
            if (wr_cnt_q < MAX_LEN_C) begin
              we_s     = 1'b1;
              wr_cnt_d = wr_cnt_q + SIZE_FIELD_W'(1);
            end else begin
              trunc_d  = 1'b1;
            end
            if (dii_last_i) begin
              state_d  = ST_SEND_SIZE;
              in_pkt_d = 1'b0;
              err_of_d = trunc_q || (wr_cnt_q >= MAX_LEN_C);
              trunc_d  = 1'b0;
            end else begin
              state_d  = ST_FILL;
            end
          end
        end else begin
          we_s = 1'b0;
        end
      end
      ST_SEND_SIZE: begin
        if (glip_ready_i) begin
          rd_cnt_d = '0;
          state_d  = ST_SEND_DATA;
        end else begin
          state_d  = ST_SEND_SIZE;
        end
      end
      ST_SEND_DATA: begin
        if (glip_ready_i) begin
          if (rd_cnt_q == wr_cnt_q - SIZE_FIELD_W'(1)) begin
            wr_cnt_d = '0;
            state_d  = ST_FILL;
          end else begin
            rd_cnt_d = rd_cnt_q + SIZE_FIELD_W'(1);
          end
        end else begin
          state_d = ST_SEND_DATA;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and error-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      in_pkt_q <= 1'b0;
      trunc_q  <= 1'b0;
      err_of_q <= 1'b0;
      err_fr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      in_pkt_q <= in_pkt_d;
      trunc_q  <= trunc_d;
      err_of_q <= err_of_d;
      err_fr_q <= err_fr_d;
    end
  end

  // Output word selected purely from registered state and buffer contents
  always_comb begin
    if (state_q == ST_SEND_SIZE) begin
      glip_data_o = {3'b000, wr_cnt_q, 8'h00};
    end else begin
      glip_data_o = bswap16(rdata_s);
    end
  end

  assign glip_valid_o   = (state_q != ST_FILL);
  assign dii_ready_o    = (state_q == ST_FILL);
  assign err_overflow_o = err_of_q;
  assign err_framing_o  = err_fr_q;

endmodule

// File: tb/tb_osd_him_egress.sv
// Scoreboard bench for osd_him_egress: a packet-level reference model
// queues expected GLIP words and error counts; a monitor pops and compares.
module tb_osd_him_egress;

  localparam int MAXL   = 16;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dii_data = 16'h0000;
  logic        dii_valid = 1'b0;
  logic        dii_first = 1'b0;
  logic        dii_last = 1'b0;
  logic        dii_ready_o;
  logic [15:0] glip_data_o;
  logic        glip_valid_o;
  logic        glip_ready = 1'b1;
  logic        err_overflow_o;
  logic        err_framing_o;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] m_buf[$];
  bit          m_in_pkt = 1'b0;
  bit          m_trunc = 1'b0;
  int          exp_fr = 0, exp_of = 0;
  int          obs_fr = 0, obs_of = 0;

  bit          ready_auto = 1'b1;
  int          ready_mode = 0;
  bit          held_v = 1'b0;
  logic [15:0] held_d = 16'h0000;

  osd_him_egress #(.MAX_PKT_LEN(MAXL)) dut (
    .clk            (clk),
    .rst            (rst),
    .dii_data_i     (dii_data),
    .dii_valid_i    (dii_valid),
    .dii_first_i    (dii_first),
    .dii_last_i     (dii_last),
    .dii_ready_o    (dii_ready_o),
    .glip_data_o    (glip_data_o),
    .glip_valid_o   (glip_valid_o),
    .glip_ready_i   (glip_ready),
    .err_overflow_o (err_overflow_o),
    .err_framing_o  (err_framing_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: one accepted DII word at a time, packet-level rules
  task automatic model_word(input logic [15:0] d, input bit f, input bit l);
    bit ends;
    ends = 1'b0;
    if (f) begin
      if (m_in_pkt) exp_fr++;
      m_buf.delete();
      m_buf.push_back(d);
      m_in_pkt = 1'b1;
      m_trunc  = 1'b0;
      ends     = l;
    end else if (!m_in_pkt) begin
      exp_fr++;
    end else begin
      if (m_buf.size() < MAXL) m_buf.push_back(d);
      else m_trunc = 1'b1;
      ends = l;
    end
    if (ends) begin
      if (m_trunc) exp_of++;
      exp_q.push_back(16'(m_buf.size()) << 8);
      foreach (m_buf[i]) exp_q.push_back({m_buf[i][7:0], m_buf[i][15:8]});
      m_in_pkt = 1'b0;
      m_trunc  = 1'b0;
    end
  endtask

  task automatic issue(input logic [15:0] d, input bit f, input bit l);
    int n;
    model_word(d, f, l);
    dii_data  = d;
    dii_first = f;
    dii_last  = l;
    dii_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dii_ready_o && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    if (n >= BUDGET) begin
      checks++;
      failures++;
      $display("FAIL dii_accept_timeout: ready stayed %0b, expected 1", dii_ready_o);
    end
    @(posedge clk);
    #1;
    dii_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || glip_valid_o) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= BUDGET), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("framing_count", 32'(obs_fr), 32'(exp_fr));
    check("overflow_count", 32'(obs_of), 32'(exp_of));
  endtask

  // GLIP ready pattern generator
  always @(posedge clk) begin
    #1;
    if (ready_auto) begin
      case (ready_mode)
        0: glip_ready = 1'b1;
        1: glip_ready = ~glip_ready;
        default: glip_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops, stall-hold and input-blocking checks
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (glip_valid_o) check("dii_ready_while_sending", 32'(dii_ready_o), 32'd0);
      if (held_v) begin
        check("stall_valid_hold", 32'(glip_valid_o), 32'd1);
        check("stall_data_hold", 32'(glip_data_o), 32'(held_d));
      end
      if (glip_valid_o && glip_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(glip_data_o), 32'hFFFF_FFFF);
        end else begin
          check("glip_word", 32'(glip_data_o), 32'(exp_q.pop_front()));
        end
      end
      held_v = glip_valid_o && !glip_ready;
      held_d = glip_data_o;
      if (err_overflow_o) obs_of++;
      if (err_framing_o) obs_fr++;
    end
  end

  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_glip_valid", 32'(glip_valid_o), 32'd0);
    check("reset_dii_ready", 32'(dii_ready_o), 32'd1);
    check("reset_err_overflow", 32'(err_overflow_o), 32'd0);
    check("reset_err_framing", 32'(err_framing_o), 32'd0);
    @(posedge clk);
    #1;

    // 3-word packet; size word must be valid the cycle after the last word
    issue(16'h0102, 1'b1, 1'b0);
    issue(16'h0304, 1'b0, 1'b0);
    issue(16'h0506, 1'b0, 1'b1);
    @(negedge clk);
    check("size_latency_valid", 32'(glip_valid_o), 32'd1);
    check("size_latency_data", 32'(glip_data_o), 32'h0300);
    drain();

    issue(16'hABCD, 1'b1, 1'b1);
    drain();

    // 20 words into a 16-word buffer
    for (int i = 0; i < 20; i++) issue(16'(16'h1000 + i), i == 0, i == 19);
    drain();

    // stray word while idle, then a restart mid-packet
    issue(16'hDEAD, 1'b0, 1'b0);
    issue(16'h1111, 1'b1, 1'b0);
    issue(16'h2222, 1'b0, 1'b0);
    issue(16'h3333, 1'b1, 1'b0);
    issue(16'h4444, 1'b0, 1'b1);
    drain();

    // stalled send, back-to-back packets
    ready_mode = 1;
    for (int i = 0; i < 4; i++) issue(16'(16'h5A00 + i), i == 0, i == 3);
    for (int i = 0; i < 3; i++) issue(16'(16'h6B00 + i), i == 0, i == 2);
    drain();

    // reset in the middle of SEND_DATA
    ready_auto = 1'b0;
    glip_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(16'(16'h7700 + i), i == 0, i == 4);
    @(posedge clk); #1 glip_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    glip_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_send_glip_valid", 32'(glip_valid_o), 32'd0);
    check("rst_mid_send_dii_ready", 32'(dii_ready_o), 32'd1);
    exp_q.delete();
    m_buf.delete();
    m_in_pkt = 1'b0;
    m_trunc = 1'b0;
    ready_mode = 0;
    ready_auto = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    drain();

    // randomized packets with occasional framing faults and ready patterns
    for (int p = 0; p < 40; p++) begin
      ready_mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) issue(16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin
        len = int'($urandom_range(1, 4));
        for (int i = 0; i < len; i++) issue(16'($urandom), i == 0, 1'b0);
      end
      len = int'($urandom_range(1, 20));
      for (int i = 0; i < len; i++) issue(16'($urandom), i == 0, i == len - 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osd_him_egress.md
Name: osd_him_egress

Overview:
- Egress stage of the host interface.
- Consumes DII packets from the debug interconnect and emits them on the GLIP host stream as a size word followed by the packet words.
- Uses the same wire format that the ingress path parses: big-endian 16-bit words, with the word count in the low 5 bits of the byte-swapped size word.
- A packet is fully buffered before its size is known, so this block contains a single-packet store-and-forward buffer.

Parameters:
- MAX_PKT_LEN, 16, maximum DII packet length in 16-bit words; legal range 1..31.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- dii_in  dii_channel.slave  -  packet input: data[15:0], valid, first, last, ready.
- glip_out  glip_channel.master  -  host stream output: data[15:0], valid, ready.
- err_overflow  out  1  one-cycle pulse when a packet exceeds MAX_PKT_LEN words and is truncated.
- err_framing  out  1  one-cycle pulse when a word is dropped for a framing error (no first, or first mid-packet).

Behaviour:
- States: FILL, SEND_SIZE, SEND_DATA. Reset enters FILL.
- Reset values: wr_cnt=0, rd_cnt=0, in_pkt=0, glip_out.valid=0, err_*=0. Buffer contents are don't-care.
- Reset mid-operation discards any partial or pending packet; nothing is emitted afterwards.
- dii_in.ready = (state==FILL). No input is accepted while a packet is being sent.
- FILL, transfer (valid & ready):
  - first=1: start a new packet. Write the word at address 0, wr_cnt=1, in_pkt=1.
  - If in_pkt was already 1 when first=1 arrives, pulse err_framing and discard the old partial packet.
  - first=0 and in_pkt=0: drop the word and pulse err_framing.
  - first=0 and in_pkt=1: if wr_cnt<MAX_PKT_LEN, write at wr_cnt and increment wr_cnt. Otherwise drop the word and set a sticky trunc flag.
  - last=1 (in_pkt=1 after this word): next state SEND_SIZE, in_pkt=0. If trunc is set, pulse err_overflow in the same cycle, then clear trunc.
  - first=1 and last=1 together form a 1-word packet.
- SEND_SIZE:
  - glip_out.valid=1, glip_out.data = {3'b0, wr_cnt[4:0], 8'h00}. This is byte-swapped, so the ingress parser reads size=wr_cnt.
  - On ready: rd_cnt=0, go to SEND_DATA.
- SEND_DATA:
  - glip_out.valid=1, glip_out.data = {buf[rd_cnt][7:0], buf[rd_cnt][15:8]}.
  - On ready: if rd_cnt==wr_cnt-1, go to FILL with wr_cnt=0; else increment rd_cnt.
- Outputs are registered or mux-from-register, with no combinational path from dii_in to glip_out.
- The data word is held stable while valid & !ready.
- Latency: the size word is valid in the cycle after the last input word is accepted.
- Throughput: one word per cycle when glip_out.ready=1. Back-to-back packets incur one idle input cycle beyond the send time (single buffer).
- The buffer has 1 write and 1 read port with a synchronous or asynchronous read. If the read is synchronous, prefetch buf[0] during SEND_SIZE so there is no bubble between data words.

Decomposition:
- Package osd_him_pkg holds:
  - the state enum (FILL, SEND_SIZE, SEND_DATA);
  - function bswap16;
  - constant SIZE_FIELD_W=5.
- The ingress side uses the same bswap16.
- Sub-module osd_him_pktbuf: MAX_PKT_LEN x 16 single-write/single-read RAM, address width $clog2(MAX_PKT_LEN).

Test Plan:
- 3-word packet 16'h0102, 16'h0304, 16'h0506, then glip ready=1 -> output 16'h0300, 16'h0201, 16'h0403, 16'h0605. The size word appears 1 cycle after the last word; errors stay 0.
- 1-word packet (first=last=1, data 16'hABCD) -> output 16'h0100, 16'hCDAB.
- 20-word packet with MAX_PKT_LEN=16 -> err_overflow pulses once on the last word; output size 16'h1000, then the first 16 words.
- Word with first=0 while idle, then first=1 mid-packet -> err_framing pulses for each event. Only the restarted packet is emitted.
- glip_out.ready toggled 1/0 every cycle during send -> data held stable while stalled, and dii_in.ready=0 until the last data word transfers.
- rst asserted during SEND_DATA -> next cycle glip_out.valid=0 and dii_in.ready=1; the remainder of the packet is never emitted.
